alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits (legal values 8..64, power of two).
REQ-002 SHALL derive localparam SH_BITS = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clock  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  operation request.
REQ-006 SHALL have port in_ready  out  1  block can accept a request this cycle.
REQ-007 SHALL have ports A, B  in  WIDTH  operands.
REQ-008 SHALL have port FS  in  5  function select: FS[0] invert B, FS[1] invert A, FS[4:2] op (000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR, 110 MUL, 111 ASR).
REQ-009 SHALL have port C0  in  1  adder carry-in.
REQ-010 SHALL have port out_valid  out  1  one-cycle pulse, F/status valid.
REQ-011 SHALL have port F  out  WIDTH  registered result.
REQ-012 SHALL have port status  out  4  registered flags {V, C, N, Z}.

Function
REQ-013 SHALL accept a request on a rising edge where in_valid && in_ready; in_valid with in_ready low SHALL be ignored (no queuing).
REQ-014 SHALL implement states IDLE and MUL; IDLE->MUL on accepted MUL, MUL->IDLE after WIDTH iterations; all other ops stay in IDLE.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in MUL.
REQ-016 Single-cycle ops (all except MUL) SHALL register F/status at the accept edge, out_valid high the following cycle; back-to-back acceptance every cycle SHALL be supported.
REQ-017 MUL SHALL run WIDTH shift-add iterations, one per cycle; result registered at accept edge + WIDTH; out_valid high the following cycle, in the same cycle in_ready returns to 1.
REQ-018 Logic/ADD/MUL operands SHALL be As = FS[1]?~A:A, Bs = FS[0]?~B:B; logic ops bitwise.
REQ-019 ADD: F = As+Bs+C0 mod 2^WIDTH; C = carry out; V = (As[MSB]==Bs[MSB]) && (F[MSB]!=As[MSB]).
REQ-020 Shifts SHALL use raw A, amount B[SH_BITS-1:0]; LSR zero-fills, ASR sign-fills; C = last bit shifted out (0 when amount 0); V = 0.
REQ-021 MUL: F = low WIDTH bits of unsigned As*Bs; C = 1 iff high WIDTH bits nonzero; V = 0.
REQ-022 For all ops N = F[WIDTH-1], Z = (F==0); AND/OR/XOR SHALL set C = V = 0.
REQ-023 F and status SHALL hold their last value between results; out_valid SHALL be 0 whenever no result completes.

Reset
REQ-024 reset SHALL force state IDLE, F = 0, status = 0000, out_valid = 0, in_ready = 1 on the next edge.
REQ-025 reset during MUL SHALL abort it with no out_valid pulse; reset SHALL take priority over a same-edge accept.

Configuration
REQ-026 Macro ALU_MUL_EN defined: MUL as REQ-017/021 and sub-module instantiated.
REQ-027 ALU_MUL_EN undefined: FS[4:2]=110 SHALL be single-cycle, F = 0, status = 0001, MUL state and sub-module absent, in_ready constantly 1 outside reset.

Structure
REQ-028 Package alu_pkg SHALL hold the op-select enum (3 bits) and status bit-index constants V=3, C=2, N=1, Z=0.
REQ-029 Iterative multiplier SHALL be sub-module alu_shift_add_mul (start, WIDTH-parameterised, done pulse, product low/high-nonzero outputs).

Verification (WIDTH=64 unless noted)
REQ-030 ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, FS=01000, C0=0 -> next cycle out_valid, F=0x8000_0000_0000_0000, status=1010.
REQ-031 SUB FS=01001, C0=1, A=5, B=5 -> F=0, status=0101; back-to-back AND next cycle accepted, out_valid two consecutive cycles.
REQ-032 MUL A=0xFFFF_FFFF, B=0x1_0000_0001, FS=11000 -> in_ready low 64 cycles, out_valid at accept+65 cycles, F=0xFFFF_FFFF_FFFF_FFFF, status=0010; in_valid pulses during MUL ignored.
REQ-033 ASR A=0x8000_0000_0000_0001, B=1 -> F=0xC000_0000_0000_0000, status=0110; LSR same -> F=0x4000_0000_0000_0000, status=0100.
REQ-034 reset asserted at MUL iteration 10 -> no out_valid, in_ready=1, F=0, status=0000 next cycle; new ADD then completes normally.
REQ-035 WIDTH=8 build without ALU_MUL_EN: FS=11000 -> F=0x00, status=0001 after one cycle, in_ready never drops.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op-select encoding and status bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_LSL = 3'b100,
        OP_LSR = 3'b101,
        OP_MUL = 3'b110,
        OP_ASR = 3'b111
    } op_e;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_shift_add_mul #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             high_nz
);

    localparam int SH_BITS = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SH_BITS-1:0] cnt;
    logic               busy;

    // Outputs are taken from the final accumulation itself, so the product is
    // available in the same cycle as the last iteration rather than one later.
    always_comb begin
        acc_next = mplier[0] ? acc + mcand : acc;
    end

    assign done    = busy && (cnt == SH_BITS'(WIDTH - 1));
    assign product = acc_next[WIDTH-1:0];
    assign high_nz = |acc_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with single-cycle logic/add/shift ops and an optional iterative multiply.
// Define ALU_MUL_EN to build the multicycle MUL path; otherwise MUL returns zero in one cycle.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FS,
    input  logic             C0,
    output logic             out_valid,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       status
);

    localparam int SH_BITS = $clog2(WIDTH);

    op_e                op;
    logic [WIDTH-1:0]   a_s;
    logic [WIDTH-1:0]   b_s;
    logic [SH_BITS-1:0] amt;
    logic               accept;
    logic               single_accept;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     lsl_ext;
    logic [WIDTH:0]     lsr_ext;
    logic [WIDTH:0]     asr_ext;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic               ovf;
    logic [3:0]         flags;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_product;
    logic               mul_high_nz;
    logic [3:0]         mul_flags;

    assign op     = op_e'(FS[4:2]);
    assign a_s    = FS[1] ? ~A : A;
    assign b_s    = FS[0] ? ~B : B;
    assign amt    = B[SH_BITS-1:0];
    assign accept = in_valid && in_ready;

    // Shifts run on a one-bit-extended operand so the extra bit catches the
    // last bit shifted out, which is naturally zero for a zero shift amount.
    assign sum_ext = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, C0};
    assign lsl_ext = {1'b0, A} << amt;
    assign lsr_ext = {A, 1'b0} >> amt;
    assign asr_ext = $signed({A, 1'b0}) >>> amt;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_AND: res = a_s & b_s;
            OP_OR:  res = a_s | b_s;
            OP_XOR: res = a_s ^ b_s;
            OP_ADD: begin
                res   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (res[WIDTH-1] != a_s[WIDTH-1]);
            end
            OP_LSL: begin
                res   = lsl_ext[WIDTH-1:0];
                carry = lsl_ext[WIDTH];
            end
            OP_LSR: begin
                res   = lsr_ext[WIDTH:1];
                carry = lsr_ext[0];
            end
            OP_ASR: begin
                res   = asr_ext[WIDTH:1];
                carry = asr_ext[0];
            end
            OP_MUL: res = '0;
            default: res = '0;
        endcase
        flags       = '0;
        flags[ST_V] = ovf;
        flags[ST_C] = carry;
        flags[ST_N] = res[WIDTH-1];
        flags[ST_Z] = (res == '0);
    end

    always_comb begin
        mul_flags       = '0;
        mul_flags[ST_C] = mul_high_nz;
        mul_flags[ST_N] = mul_product[WIDTH-1];
        mul_flags[ST_Z] = (mul_product == '0);
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_e;

    state_e state;
    state_e next_state;
    logic   mul_start;

    assign mul_start     = accept && (op == OP_MUL);
    assign single_accept = accept && (op != OP_MUL);
    assign in_ready      = (state == S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (mul_start) next_state = S_MUL;
            S_MUL:  if (mul_done)  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    alu_shift_add_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clock  (clock),
        .reset  (reset),
        .start  (mul_start),
        .a      (a_s),
        .b      (b_s),
        .done   (mul_done),
        .product(mul_product),
        .high_nz(mul_high_nz)
    );
`else
    assign single_accept = accept;
    assign in_ready      = 1'b1;
    assign mul_done      = 1'b0;
    assign mul_product   = '0;
    assign mul_high_nz   = 1'b0;
`endif

    // Results from either path land in the same registers; the FSM guarantees
    // a single-cycle accept never coincides with a multiply completing.
    always_ff @(posedge clock) begin
        if (reset) begin
            F         <= '0;
            status    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (single_accept) begin
                F         <= res;
                status    <= flags;
                out_valid <= 1'b1;
            end else if (mul_done) begin
                F         <= mul_product;
                status    <= mul_flags;
                out_valid <= 1'b1;
            end
        end
    end

endmodule
